// File: rtl/led_decoder.sv
// rtl/led_decoder.sv - seven-segment scan decoder assembling four-digit frames
module led_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  dig_sel,
   output logic [15:0] value,
   output logic        valid,
   output logic        err
);

   localparam logic [7:0] C_CNT_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] C_CNT_CAP = 8'(STABLE_CYCLES - 2);

   logic [10:0]      r_prev;
   logic [7:0]       r_cnt;
   logic [3:0]       r_mask;
   logic             r_ferr;
   logic [3:0][3:0]  r_slots;
   logic [15:0]      r_value;
   logic             r_valid;
   logic             r_err;

   logic [10:0]      w_sample;
   logic             w_same;
   logic             w_onehot;
   logic             w_blank;
   logic             w_capture;
   logic [1:0]       w_idx;
   logic [3:0]       w_nibble;
   logic             w_bad;
   logic [3:0]       w_mask_nxt;
   logic             w_done;
   logic [3:0][3:0]  w_frame;

   assign w_sample = {seg, dig_sel};
   assign w_same   = (w_sample == r_prev);
   assign w_onehot = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
   assign w_blank  = (seg == 7'h00);

   // Capture fires once per run: only on the step into the saturated count.
   assign w_capture = w_same && (r_cnt == C_CNT_CAP) && w_onehot && !w_blank;

   always_comb begin
      w_nibble = 4'h0;
      w_bad    = 1'b0;
      case (seg)
         7'h3F: w_nibble = 4'h0;
         7'h06: w_nibble = 4'h1;
         7'h5B: w_nibble = 4'h2;
         7'h4F: w_nibble = 4'h3;
         7'h66: w_nibble = 4'h4;
         7'h6D: w_nibble = 4'h5;
         7'h7D: w_nibble = 4'h6;
         7'h07: w_nibble = 4'h7;
         7'h7F: w_nibble = 4'h8;
         7'h6F: w_nibble = 4'h9;
         7'h77: w_nibble = 4'hA;
         7'h7C: w_nibble = 4'hB;
         7'h39: w_nibble = 4'hC;
         7'h5E: w_nibble = 4'hD;
         7'h79: w_nibble = 4'hE;
         7'h71: w_nibble = 4'hF;
         default: begin
            w_nibble = 4'h0;
            w_bad    = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_idx = 2'd0;
      case (dig_sel)
         4'b0001: w_idx = 2'd0;
         4'b0010: w_idx = 2'd1;
         4'b0100: w_idx = 2'd2;
         4'b1000: w_idx = 2'd3;
         default: w_idx = 2'd0;
      endcase
   end

   // The completed frame must include the digit being captured on this edge.
   always_comb begin
      w_mask_nxt     = r_mask | dig_sel;
      w_done         = (w_mask_nxt == 4'hF);
      w_frame        = r_slots;
      w_frame[w_idx] = w_nibble;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_prev <= w_sample;
         if (!w_same)
            r_cnt <= '0;
         else if (r_cnt != C_CNT_MAX)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mask  <= '0;
         r_ferr  <= 1'b0;
         r_slots <= '0;
         r_value <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_capture) begin
            r_slots[w_idx] <= w_nibble;
            if (w_done) begin
               r_value <= w_frame;
               r_err   <= r_ferr | w_bad;
               r_valid <= 1'b1;
               r_mask  <= '0;
               r_ferr  <= 1'b0;
            end else begin
               r_mask  <= w_mask_nxt;
               r_ferr  <= r_ferr | w_bad;
            end
         end
      end
   end

   assign value = r_value;
   assign valid = r_valid;
   assign err   = r_err;

endmodule

// File: tb/tb_led_decoder.sv
// tb/tb_led_decoder.sv - directed table, corner sequences and random run against a run-length model
module tb_led_decoder;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;
   logic [15:0] value;
   logic        valid;
   logic        err;

   always #5 clk = ~clk;

   led_decoder #(.STABLE_CYCLES(S)) dut (
      .clk     (clk),
      .rst     (rst),
      .seg     (seg),
      .dig_sel (dig_sel),
      .value   (value),
      .valid   (valid),
      .err     (err)
   );

   int n_vec = 0;
   int n_bad = 0;
   int pulses = 0;

   logic [6:0]  pat [16];

   // Model: a digit is taken when the same input has been seen exactly S times in a row.
   logic [10:0] m_last;
   int          m_run;
   logic [3:0]  m_slot [4];
   logic [3:0]  m_mask;
   logic        m_ferr;
   logic [15:0] m_value;
   logic        m_valid;
   logic        m_err;

   typedef struct {
      logic [6:0]  seg;
      logic [3:0]  sel;
      int          n;
      int          pulses;
      logic [15:0] value;
      logic        err;
   } step_t;

   step_t tbl [$];

   function automatic step_t mk(input logic [6:0] s, input logic [3:0] d, input int n,
                                input int p, input logic [15:0] v, input logic e);
      step_t t;
      t.seg = s; t.sel = d; t.n = n; t.pulses = p; t.value = v; t.err = e;
      return t;
   endfunction

   function automatic int lookup(input logic [6:0] s);
      for (int i = 0; i < 16; i++)
         if (pat[i] == s) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [6:0] s, input logic [3:0] d);
      int k;
      int code;
      m_valid = 1'b0;
      if (r) begin
         m_last = '0; m_run = 1; m_mask = '0; m_ferr = 1'b0;
         m_value = '0; m_err = 1'b0;
         for (int i = 0; i < 4; i++) m_slot[i] = '0;
         return;
      end
      if ({s, d} == m_last) m_run++;
      else begin
         m_last = {s, d};
         m_run  = 1;
      end
      if (m_run == S && $countones(d) == 1 && s != 7'h00) begin
         k = 0;
         for (int i = 0; i < 4; i++) if (d[i]) k = i;
         code = lookup(s);
         m_slot[k] = (code < 0) ? 4'h0 : code[3:0];
         m_ferr    = m_ferr | (code < 0);
         m_mask[k] = 1'b1;
         if (m_mask == 4'hF) begin
            m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_err   = m_ferr;
            m_valid = 1'b1;
            m_mask  = '0;
            m_ferr  = 1'b0;
         end
      end
   endtask

   task automatic cycle(input logic r, input logic [6:0] s, input logic [3:0] d);
      rst = r; seg = s; dig_sel = d;
      @(posedge clk);
      model_step(r, s, d);
      #1;
      chk("model valid", {15'd0, valid}, {15'd0, m_valid});
      chk("model value", value, m_value);
      chk("model err", {15'd0, err}, {15'd0, m_err});
      if (valid) pulses++;
   endtask

   task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, s, d);
   endtask

   task automatic step(input string name, input logic [6:0] s, input logic [3:0] d, input int n,
                       input int p, input logic [15:0] v, input logic e);
      int p0;
      p0 = pulses;
      hold(s, d, n);
      chk({name, " pulses"}, 16'(pulses - p0), 16'(p));
      chk({name, " value"}, value, v);
      chk({name, " err"}, {15'd0, err}, {15'd0, e});
   endtask

   task automatic reset_pulse(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 7'h00, 4'h0);
      chk("reset value", value, 16'h0000);
      chk("reset valid", {15'd0, valid}, 16'd0);
      chk("reset err", {15'd0, err}, 16'd0);
   endtask

   initial begin
      pat[0]  = 7'h3F; pat[1]  = 7'h06; pat[2]  = 7'h5B; pat[3]  = 7'h4F;
      pat[4]  = 7'h66; pat[5]  = 7'h6D; pat[6]  = 7'h7D; pat[7]  = 7'h07;
      pat[8]  = 7'h7F; pat[9]  = 7'h6F; pat[10] = 7'h77; pat[11] = 7'h7C;
      pat[12] = 7'h39; pat[13] = 7'h5E; pat[14] = 7'h79; pat[15] = 7'h71;

      tbl.push_back(mk(7'h06, 4'b0001, 8,  0, 16'h0000, 1'b0));
      tbl.push_back(mk(7'h5B, 4'b0010, 8,  0, 16'h0000, 1'b0));
      tbl.push_back(mk(7'h00, 4'b0100, 10, 0, 16'h0000, 1'b0));
      tbl.push_back(mk(7'h4F, 4'b0100, 8,  0, 16'h0000, 1'b0));
      tbl.push_back(mk(7'h66, 4'b1000, 8,  1, 16'h4321, 1'b0));
      tbl.push_back(mk(7'h71, 4'b0001, 8,  0, 16'h4321, 1'b0));
      tbl.push_back(mk(7'h71, 4'b0010, 8,  0, 16'h4321, 1'b0));
      tbl.push_back(mk(7'h7E, 4'b0100, 8,  0, 16'h4321, 1'b0));
      tbl.push_back(mk(7'h71, 4'b1000, 8,  1, 16'hF0FF, 1'b1));
      tbl.push_back(mk(7'h06, 4'b0011, 20, 0, 16'hF0FF, 1'b1));
      tbl.push_back(mk(7'h7F, 4'b1000, 8,  0, 16'hF0FF, 1'b1));
      tbl.push_back(mk(7'h39, 4'b1000, 8,  0, 16'hF0FF, 1'b1));
      tbl.push_back(mk(7'h3F, 4'b0001, 8,  0, 16'hF0FF, 1'b1));
      tbl.push_back(mk(7'h3F, 4'b0010, 8,  0, 16'hF0FF, 1'b1));
      tbl.push_back(mk(7'h3F, 4'b0100, 8,  1, 16'hC000, 1'b0));

      model_step(1'b1, 7'h00, 4'h0);
      reset_pulse(2);

      foreach (tbl[i])
         step($sformatf("tbl%0d", i), tbl[i].seg, tbl[i].sel, tbl[i].n,
              tbl[i].pulses, tbl[i].value, tbl[i].err);

      // Stability window: S-1 samples never capture, exactly S does, 50 captures once.
      step("short run",  7'h5B, 4'b0001, S - 1, 0, 16'hC000, 1'b0);
      step("gap",        7'h00, 4'b0000, 2,     0, 16'hC000, 1'b0);
      step("stab d1",    7'h4F, 4'b0010, 8,     0, 16'hC000, 1'b0);
      step("stab d2",    7'h66, 4'b0100, 8,     0, 16'hC000, 1'b0);
      step("stab d3",    7'h7D, 4'b1000, 8,     0, 16'hC000, 1'b0);
      step("exact run",  7'h06, 4'b0001, S,     1, 16'h6431, 1'b0);
      step("long run",   7'h6F, 4'b0001, 50,    0, 16'h6431, 1'b0);
      step("long d1",    7'h07, 4'b0010, 8,     0, 16'h6431, 1'b0);
      step("long d2",    7'h07, 4'b0100, 8,     0, 16'h6431, 1'b0);
      step("long d3",    7'h7F, 4'b1000, 8,     1, 16'h8779, 1'b0);

      // A partial frame is dropped by reset.
      step("pre d0",     7'h06, 4'b0001, 8,     0, 16'h8779, 1'b0);
      step("pre d1",     7'h5B, 4'b0010, 8,     0, 16'h8779, 1'b0);
      reset_pulse(2);
      step("post d2",    7'h4F, 4'b0100, 8,     0, 16'h0000, 1'b0);
      step("post d3",    7'h66, 4'b1000, 8,     0, 16'h0000, 1'b0);
      step("post d0",    7'h3F, 4'b0001, 8,     0, 16'h0000, 1'b0);
      step("post d1",    7'h3F, 4'b0010, 8,     1, 16'h4300, 1'b0);

      for (int i = 0; i < 400; i++) begin
         logic [6:0] s;
         logic [3:0] d;
         int         r;
         r = $urandom_range(0, 9);
         if (r == 0)      s = 7'h00;
         else if (r == 1) s = 7'($urandom);
         else             s = pat[$urandom_range(0, 15)];
         if ($urandom_range(0, 9) == 0) d = 4'($urandom);
         else                           d = 4'b0001 << $urandom_range(0, 3);
         if ($urandom_range(0, 39) == 0) begin
            for (int j = 0; j < int'($urandom_range(1, 2)); j++) cycle(1'b1, s, d);
         end else begin
            hold(s, d, $urandom_range(1, 9));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
